// File: rtl/hmac_sha256_keycache_pkg.sv
// Shared types and constants for the HMAC-SHA256 engine with cached key midstates.
// Holds the FSM encoding, SHA-256 round constants and the small bit-mixing helpers.
package hmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_I,
        ST_KEY_O,
        ST_MSG_I,
        ST_MSG_O,
        ST_DONE
    } state_t;

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [7:0]  IPAD_BYTE      = 8'h36;
    localparam logic [7:0]  OPAD_BYTE      = 8'h5c;
    localparam logic [63:0] OUTER_LEN_BITS = 64'd768;

    localparam logic [0:63][31:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Compression phase that follows a given one; the key phases are skipped on reuse elsewhere.
    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_KEY_I: return ST_KEY_O;
            ST_KEY_O: return ST_MSG_I;
            ST_MSG_I: return ST_MSG_O;
            ST_MSG_O: return ST_DONE;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hmac_sha256_keycache_sha256_block.sv
// Single SHA-256 compression, one round per cycle, with valid/ready on both sides.
// h_o = h_i + compress(h_i, block_i), held while v_o is high until r_i.
module sha256_block (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [255:0] h_i,
    input  logic [511:0] block_i,
    input  logic         v_i,
    output logic         r_o,
    output logic [255:0] h_o,
    output logic         v_o,
    input  logic         r_i
);
    import hmac_pkg::*;

    logic                busy, done;
    logic [5:0]          rnd;
    logic [15:0][31:0]   w;
    logic [31:0]         va, vb, vc, vd, ve, vf, vg, vh;
    logic [255:0]        h_base;
    logic [31:0]         t1, t2, w_nxt;
    logic [7:0][31:0]    work;

    assign r_o = !busy && !done;
    assign v_o = done;

    // w[0] is the schedule word for the current round; w_nxt is W[t+16].
    always_comb begin
        t1    = vh + bsig1(ve) + ((ve & vf) ^ (~ve & vg)) + SHA256_K[rnd] + w[0];
        t2    = bsig0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
        w_nxt = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy <= 1'b0;
            done <= 1'b0;
            rnd  <= '0;
        end else if (v_i && r_o) begin
            busy <= 1'b1;
            rnd  <= '0;
        end else if (busy) begin
            rnd <= rnd + 6'd1;
            if (rnd == 6'd63) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else if (done && r_i) begin
            done <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i && r_o) begin
            h_base <= h_i;
            {va, vb, vc, vd, ve, vf, vg, vh} <= h_i;
            for (int k = 0; k < 16; k++) w[k] <= block_i[511-32*k -: 32];
        end else if (busy) begin
            va <= t1 + t2;
            vb <= va;
            vc <= vb;
            vd <= vc;
            ve <= vd + t1;
            vf <= ve;
            vg <= vf;
            vh <= vg;
            w  <= {w_nxt, w[15:1]};
        end
    end

    assign work = {va, vb, vc, vd, ve, vf, vg, vh};
    for (genvar j = 0; j < 8; j++) begin : g_sum
        assign h_o[32*j +: 32] = h_base[32*j +: 32] + work[j];
    end

endmodule

// File: rtl/hmac_sha256_keycache.sv
// HMAC-SHA256 over a single-block message, caching the ipad/opad midstates so a
// repeated key costs two compressions instead of four. One shared compression core.
module hmac_sha256_keycache #(
    parameter int MSG_BYTES_MAX = 55,
    parameter int LEN_W         = $clog2(MSG_BYTES_MAX + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [511:0]               key_i,
    input  logic                       key_new_i,
    input  logic [8*MSG_BYTES_MAX-1:0] msg_i,
    input  logic [LEN_W-1:0]           msg_len_i,
    input  logic                       v_i,
    output logic                       r_o,
    output logic [255:0]               prf_o,
    output logic                       v_o,
    input  logic                       r_i,
    output logic                       key_cached_o
);
    import hmac_pkg::*;

    localparam int MSG_W = 8 * MSG_BYTES_MAX;

    state_t             state, state_nxt;
    logic               issued, accept, sb_done, fresh, cached;
    logic [511:0]       key_q;
    logic [MSG_W-1:0]   msg_q;
    logic [LEN_W-1:0]   len_q, len_clamp;
    logic [255:0]       inner_ms, outer_ms, ihash, prf_q;
    logic [447:0]       body;
    logic [511:0]       msg_blk;

    logic               sb_v, sb_r, sb_r_o, sb_v_o;
    logic [255:0]       sb_h, sb_h_o;
    logic [511:0]       sb_blk;

    assign fresh        = key_new_i || !cached;
    assign len_clamp    = (msg_len_i > LEN_W'(MSG_BYTES_MAX)) ? LEN_W'(MSG_BYTES_MAX) : msg_len_i;
    assign key_cached_o = cached;
    assign prf_o        = prf_q;

    // Bytes past the length are dropped and the 0x80 marker lands right after the last kept byte.
    for (genvar i = 0; i < 56; i++) begin : g_byte
        if (i < MSG_BYTES_MAX) begin : g_msg
            assign body[447-8*i -: 8] = (32'(len_q) > i)  ? msg_q[MSG_W-1-8*i -: 8] :
                                        (32'(len_q) == i) ? 8'h80 : 8'h00;
        end else begin : g_pad
            assign body[447-8*i -: 8] = (32'(len_q) == i) ? 8'h80 : 8'h00;
        end
    end
    // Inner hash length counts the 64-byte ipad block ahead of the message.
    assign msg_blk = {body, 64'd512 + (64'(len_q) << 3)};

    always_comb begin
        sb_h   = SHA256_IV;
        sb_blk = key_q ^ {64{IPAD_BYTE}};
        case (state)
            ST_KEY_O: sb_blk = key_q ^ {64{OPAD_BYTE}};
            ST_MSG_I: begin
                sb_h   = inner_ms;
                sb_blk = msg_blk;
            end
            ST_MSG_O: begin
                sb_h   = outer_ms;
                sb_blk = {ihash, 8'h80, 184'h0, OUTER_LEN_BITS};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sb_v      = 1'b0;
        sb_r      = 1'b0;
        sb_done   = 1'b0;
        r_o       = 1'b0;
        v_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                r_o = !rst_i;
                if (v_i && !rst_i) begin
                    accept    = 1'b1;
                    state_nxt = fresh ? ST_KEY_I : ST_MSG_I;
                end
            end
            ST_KEY_I, ST_KEY_O, ST_MSG_I, ST_MSG_O: begin
                sb_v = !issued;
                sb_r = 1'b1;
                if (sb_v_o) begin
                    sb_done   = 1'b1;
                    state_nxt = next_phase(state);
                end
            end
            ST_DONE: begin
                v_o = !rst_i;
                if (r_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            issued   <= 1'b0;
            cached   <= 1'b0;
            key_q    <= '0;
            msg_q    <= '0;
            len_q    <= '0;
            inner_ms <= '0;
            outer_ms <= '0;
            ihash    <= '0;
            prf_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                key_q <= key_i;
                msg_q <= msg_i;
                len_q <= len_clamp;
                // Midstates are about to be overwritten; they are not trustworthy until KEY_O finishes.
                if (fresh) cached <= 1'b0;
            end
            if (sb_v && sb_r_o)  issued <= 1'b1;
            else if (sb_done)    issued <= 1'b0;
            if (sb_done) begin
                case (state)
                    ST_KEY_I: inner_ms <= sb_h_o;
                    ST_KEY_O: begin
                        outer_ms <= sb_h_o;
                        cached   <= 1'b1;
                    end
                    ST_MSG_I: ihash <= sb_h_o;
                    ST_MSG_O: prf_q <= sb_h_o;
                    default: ;
                endcase
            end
        end
    end

    sha256_block u_sha (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .h_i     (sb_h),
        .block_i (sb_blk),
        .v_i     (sb_v),
        .r_o     (sb_r_o),
        .h_o     (sb_h_o),
        .v_o     (sb_v_o),
        .r_i     (sb_r)
    );

endmodule

// File: tb/tb_hmac_sha256_keycache.sv
// Directed bench for hmac_sha256_keycache: RFC vectors, key reuse, masking, clamping,
// output backpressure and reset in the middle of a request.
module tb_hmac_sha256_keycache;
    import hmac_pkg::*;

    localparam int MBM = 55;
    localparam int LW  = 6;
    localparam int MW  = 8 * MBM;

    localparam logic [511:0] K0B    = {{20{8'h0b}}, 352'h0};
    localparam logic [511:0] K_JEFE = {32'h4a656665, 480'h0};
    localparam logic [511:0] K_AA   = {{20{8'haa}}, 352'h0};
    localparam logic [511:0] K_0119 = {200'h0102030405060708090a0b0c0d0e0f10111213141516171819, 312'h0};
    localparam logic [MW-1:0] M_HI   = {"Hi There", {47{8'hff}}};
    localparam logic [MW-1:0] M_WHAT = {"what do ya want for nothing?", {27{8'ha5}}};
    localparam logic [MW-1:0] M_DD   = {{50{8'hdd}}, {5{8'h5a}}};
    localparam logic [MW-1:0] M_CD   = {{50{8'hcd}}, {5{8'hc3}}};
    localparam logic [255:0] H_TC1  = 256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7;
    localparam logic [255:0] H_JEFE = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
    localparam logic [255:0] H_EMPTY= 256'hb613679a0814d9ec772f95d778c35fc5ff1697c493715653c6c712144292c5ad;
    localparam logic [255:0] H_TC3  = 256'h773ea91e36800e46854db8ebd09181a72959098b3ef8c122d9635514ced565fe;
    localparam logic [255:0] H_TC4  = 256'h82558a389a443c0ea4cc819899f2083a85f0faa3e578f8077a2e3ff46729665b;

    logic          clk, rst_i, key_new_i, v_i, r_o, v_o, r_i, key_cached_o;
    logic [511:0]  key_i;
    logic [MW-1:0] msg_i;
    logic [LW-1:0] msg_len_i;
    logic [255:0]  prf_o;

    hmac_sha256_keycache #(.MSG_BYTES_MAX(MBM), .LEN_W(LW)) dut (
        .clk_i(clk), .rst_i(rst_i), .key_i(key_i), .key_new_i(key_new_i),
        .msg_i(msg_i), .msg_len_i(msg_len_i), .v_i(v_i), .r_o(r_o),
        .prf_o(prf_o), .v_o(v_o), .r_i(r_i), .key_cached_o(key_cached_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0]  key;
        logic          kn;
        logic [MW-1:0] msg;
        logic [LW-1:0] len;
        logic [255:0]  exp;
    } vec_t;

    vec_t          tv [12];
    int            lat_tab [12];
    int            n_run, n_fail, excl, w, lat;
    logic [255:0]  res;
    logic [MW-1:0] m_pat;
    bit            got, hold_bad, vo_seen;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Independent reference: straight-line SHA-256 compression with a full 64-word schedule.
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] m_comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] wm [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) wm[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(wm[t-15], 7) ^ rr(wm[t-15], 18) ^ (wm[t-15] >> 3);
            s1 = rr(wm[t-2], 17) ^ rr(wm[t-2], 19) ^ (wm[t-2] >> 10);
            wm[t] = wm[t-16] + s0 + wm[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + SHA256_K[t] + wm[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] m_hmac(input logic [511:0] key, input logic [MW-1:0] msg, input int len_in);
        logic [511:0] blk;
        logic [255:0] ih;
        int           n;
        n   = (len_in > MBM) ? MBM : len_in;
        blk = '0;
        for (int i = 0; i < MBM; i++) if (i < n) blk[511-8*i -: 8] = msg[MW-1-8*i -: 8];
        blk[511-8*n -: 8] = 8'h80;
        blk[63:0] = 64'(512 + 8 * n);
        ih = m_comp(m_comp(SHA256_IV, key ^ {64{8'h36}}), blk);
        return m_comp(m_comp(SHA256_IV, key ^ {64{8'h5c}}), {ih, 8'h80, 184'h0, 64'd768});
    endfunction

    // One request: wait for ready, hand over, scramble inputs, wait for the result,
    // optionally hold r_i low for 'hold' cycles, then consume it.
    task automatic send(input logic [511:0] key, input logic kn, input logic [MW-1:0] msg,
                        input logic [LW-1:0] len, input int hold,
                        output logic [255:0] r, output int lt, output bit ok, output bit hbad);
        int wt;
        ok = 0; lt = 0; r = '0; hbad = 0; wt = 0;
        @(negedge clk);
        while (!r_o && wt < 100) begin @(negedge clk); wt++; end
        key_i = key; key_new_i = kn; msg_i = msg; msg_len_i = len; v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        key_new_i = ~kn;
        msg_len_i = LW'($urandom);
        for (int k = 0; k < 64; k++) key_i[8*k +: 8] = 8'($urandom);
        for (int k = 0; k < MBM; k++) msg_i[8*k +: 8] = 8'($urandom);
        while (lt < 2000) begin
            @(negedge clk);
            lt++;
            if (r_o && v_o) excl++;
            if (v_o) begin ok = 1; break; end
        end
        if (ok) begin
            r = prf_o;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!v_o || r_o || prf_o !== r) hbad = 1;
            end
            r_i = 1'b1;
            @(posedge clk); #1;
            r_i = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_run = 0; n_fail = 0; excl = 0;
        rst_i = 1'b1; v_i = 1'b0; r_i = 1'b0; key_new_i = 1'b0;
        key_i = '0; msg_i = '0; msg_len_i = '0;
        for (int i = 0; i < MBM; i++) m_pat[MW-1-8*i -: 8] = 8'(i * 37 + 11);

        tv[0]  = '{K0B,    1'b1, M_HI,    6'd8,  H_TC1};
        tv[1]  = '{K_JEFE, 1'b1, M_WHAT,  6'd28, H_JEFE};
        tv[2]  = '{K_JEFE, 1'b0, M_WHAT,  6'd28, H_JEFE};
        tv[3]  = '{K0B,    1'b0, M_WHAT,  6'd28, H_JEFE};
        tv[4]  = '{512'h0, 1'b1, {MW{1'b1}}, 6'd0, H_EMPTY};
        tv[5]  = '{K_AA,   1'b1, M_DD,    6'd50, H_TC3};
        tv[6]  = '{K_0119, 1'b1, M_CD,    6'd50, H_TC4};
        tv[7]  = '{512'h0, 1'b0, M_CD,    6'd50, H_TC4};
        tv[8]  = '{K_JEFE, 1'b1, m_pat,   6'd55, m_hmac(K_JEFE, m_pat, 55)};
        tv[9]  = '{512'h0, 1'b0, m_pat,   6'd56, m_hmac(K_JEFE, m_pat, 55)};
        tv[10] = '{512'h0, 1'b0, m_pat,   6'd63, m_hmac(K_JEFE, m_pat, 55)};
        tv[11] = '{K_JEFE, 1'b1, m_pat,   6'd54, m_hmac(K_JEFE, m_pat, 54)};

        repeat (3) @(negedge clk);
        chk("rst_r_o", r_o, 0);
        chk("rst_v_o", v_o, 0);
        chk("rst_prf", prf_o, 0);
        chk("rst_cached", key_cached_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_r_o", r_o, 1);

        for (int i = 0; i < 12; i++) begin
            send(tv[i].key, tv[i].kn, tv[i].msg, tv[i].len, 0, res, lat, got, hold_bad);
            lat_tab[i] = lat;
            if (!got) chk($sformatf("vec%0d_timeout", i), 0, 1);
            else      chk($sformatf("vec%0d", i), res, tv[i].exp);
        end
        chk("cached_after", key_cached_o, 1);
        // Reuse skips two of four compressions, so a fresh key takes about twice as long.
        chk("lat_key_reuse", (lat_tab[1] >= 2 * lat_tab[2] - 4) && (lat_tab[1] <= 2 * lat_tab[2] + 4), 1);

        send(K0B, 1'b1, M_HI, 6'd8, 20, res, lat, got, hold_bad);
        chk("bp_result", got ? res : 256'h0, H_TC1);
        chk("bp_hold", hold_bad, 0);
        @(negedge clk);
        chk("bp_vo_drop", v_o, 0);
        chk("bp_ro_back", r_o, 1);

        w = 0;
        while (!r_o && w < 100) begin @(negedge clk); w++; end
        key_i = K_JEFE; key_new_i = 1'b1; msg_i = M_WHAT; msg_len_i = 6'd28; v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        w = 0;
        while (!key_cached_o && w < 1000) begin @(negedge clk); w++; end
        chk("mid_cache_set", key_cached_o, 1);
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_r_o", r_o, 0);
        chk("mid_rst_v_o", v_o, 0);
        chk("mid_rst_cached", key_cached_o, 0);
        chk("mid_rst_prf", prf_o, 0);
        rst_i = 1'b0;
        vo_seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (v_o) vo_seen = 1;
        end
        chk("mid_no_stale_vo", vo_seen, 0);
        send(K_JEFE, 1'b0, M_WHAT, 6'd28, 0, res, lat, got, hold_bad);
        chk("mid_recompute", got ? res : 256'h0, H_JEFE);
        chk("mid_forced_lat", lat > lat_tab[2] + 50, 1);

        chk("ro_vo_exclusive", excl, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
